// File: rtl/eth_rx_mem_reader.sv
// Host-side reader for the Ethernet RX capture memory: issues port-B reads, absorbs the RAM latency
// and streams the bytes out as valid/ready with a last flag. Optional LFSR payload check: RX_LFSR_CHECK_EN.
module eth_rx_mem_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_byte_count,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [7:0]            i_mem_data,
`ifdef RX_LFSR_CHECK_EN
  input  logic [7:0]            i_lfsr_data,
`endif
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_lfsr_enable,
  output logic [15:0]           o_err_count
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state, state_n;
  logic [RD_LATENCY-1:0] vpipe, vpipe_n;
  logic [7:0]            buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]      buf_cnt, buf_cnt_n;
  logic [LEN_WIDTH-1:0]  remain, remain_n, total, total_n, out_idx, out_idx_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [7:0]            head_n;
  logic                  issue, wr, pop, abort_now, space, pipe_empty_n;

  // Next-state, issue and buffer bookkeeping
  always_comb begin
    state_n      = state;
    issue        = 1'b0;
    addr_n       = o_mem_addr;
    remain_n     = remain;
    total_n      = total;
    pop          = o_valid & i_ready;
    out_idx_n    = out_idx + LEN_WIDTH'(pop);
    abort_now    = i_abort && ((state == S_READ) || (state == S_DRAIN));
    wr           = vpipe[RD_LATENCY-1] && (state != S_FLUSH) && !abort_now;
    space        = (32'($countones(vpipe)) + 32'(buf_cnt)) < BUF_DEPTH;
    pipe_empty_n = (RD_LATENCY'({vpipe, 1'b0}) == '0);
    if (abort_now) begin
      rd_ptr_n  = '0;
      wr_ptr_n  = '0;
      buf_cnt_n = '0;
    end else begin
      rd_ptr_n  = rd_ptr + PTR_W'(pop);
      wr_ptr_n  = wr_ptr + PTR_W'(wr);
      buf_cnt_n = buf_cnt + CNT_W'(wr) - CNT_W'(pop);
    end
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_byte_count == '0) begin
            state_n = S_DONE;
          end else begin
            // First address goes out on the start edge so data lands RD_LATENCY edges later
            issue     = 1'b1;
            addr_n    = i_base_addr;
            remain_n  = i_byte_count - LEN_WIDTH'(1);
            total_n   = i_byte_count;
            out_idx_n = '0;
            state_n   = S_READ;
          end
        end
      end
      S_READ: begin
        if (abort_now) begin
          state_n = S_FLUSH;
        end else if (remain == '0) begin
          state_n = S_DRAIN;
        end else if (space) begin
          issue    = 1'b1;
          addr_n   = o_mem_addr + ADDR_WIDTH'(1);
          remain_n = remain - LEN_WIDTH'(1);
          if (remain == LEN_WIDTH'(1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_now) state_n = S_FLUSH;
        else if ((buf_cnt_n == '0) && pipe_empty_n) state_n = S_DONE;
      end
      S_FLUSH: begin
        if (pipe_empty_n) state_n = S_IDLE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    vpipe_n = RD_LATENCY'({vpipe, issue});
    head_n  = (wr && (wr_ptr == rd_ptr_n)) ? i_mem_data : buf_mem[rd_ptr_n];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      vpipe      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      buf_cnt    <= '0;
      remain     <= '0;
      total      <= '0;
      out_idx    <= '0;
      o_mem_addr <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_n;
      vpipe      <= vpipe_n;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      buf_cnt    <= buf_cnt_n;
      remain     <= remain_n;
      total      <= total_n;
      out_idx    <= out_idx_n;
      o_mem_addr <= addr_n;
      if (buf_cnt_n != '0) o_data <= head_n;
      o_valid    <= (buf_cnt_n != '0);
      o_last     <= (buf_cnt_n != '0) && (out_idx_n == total_n - LEN_WIDTH'(1));
      o_busy     <= (state_n != S_IDLE);
      o_done     <= (state_n == S_DONE);
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by buf_cnt
  always_ff @(posedge i_clk) begin
    if (wr) buf_mem[wr_ptr] <= i_mem_data;
  end

`ifdef RX_LFSR_CHECK_EN
  // Generator must advance in the same cycle as the accepted beat
  assign o_lfsr_enable = pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_count <= '0;
    end else if ((state == S_IDLE) && i_start) begin
      o_err_count <= '0;
    end else if (pop && (o_data != i_lfsr_data) && (o_err_count != 16'hFFFF)) begin
      o_err_count <= o_err_count + 16'd1;
    end
  end
`else
  assign o_lfsr_enable = 1'b0;
  assign o_err_count   = '0;
`endif

endmodule
